rr_arb8_idx: RTL and testbench

RR_ARB8_IDX -- requirements
Module: rr_arb8_idx

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_pick8.sv | 40 ++++
 rtl/rr_arb8_idx.sv | 127 ++++++++++++
 tb/tb_rr_arb8_idx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared constants and types for the 8-way round-robin index arbiter and the
// 3-to-8 decode stage that consumes its grant index.
//   N     : number of requesters (only 8 is supported)
//   IDXW  : width of a binary requester index
//   CNTW  : width of the accepted-grant counter
//   state_e : arbiter FSM states (IDLE = no grant offered, OFFER = grant held)
// ---------------------------------------------------------------------------
package arb_pkg;

   localparam int N    = 8;
   localparam int IDXW = 3;
   localparam int CNTW = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_e;

endpackage

// File: rtl/rr_pick8.sv
// ---------------------------------------------------------------------------
// rr_pick8
// Combinational rotating first-one search. Looks at req starting at index ptr
// and walks upward (wrapping 7 -> 0), returning the first set position.
// Ports:
//   req [7:0] : request vector
//   ptr [2:0] : index searched first
//   idx [2:0] : first set request at or after ptr (0 when nothing is set)
//   any       : at least one request is set
// ---------------------------------------------------------------------------
module rr_pick8
   import arb_pkg::*;
(
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic [IDXW-1:0] idx,
   output logic            any
);

   logic [IDXW-1:0] pos;
   logic            found;

   // Walk the eight positions in priority order; the index arithmetic wraps
   // naturally because pos is only IDXW bits wide, so ptr+7 lands on ptr-1.
   always_comb begin
      idx   = '0;
      pos   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         pos = ptr + IDXW'(k);
         if (!found && req[pos]) begin
            idx   = pos;
            found = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/rr_arb8_idx.sv
// ---------------------------------------------------------------------------
// rr_arb8_idx
// Eight-requester round-robin arbiter that offers a binary grant index to a
// downstream decode stage with a valid/ready handshake and counts accepted
// grants.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   req       : request vector, bit i = requester i wants service
//   gnt_ready : downstream accepts the offered index this cycle
//   lock      : (only with ARB_LOCK_EN) keep priority on the current winner
//   gnt_vld   : registered, gnt_idx holds a valid grant
//   gnt_idx   : registered binary index of the granted requester
//   gnt_cnt   : registered count of accepted grants, wraps 255 -> 0
// Build option:
//   ARB_LOCK_EN : when defined, adds the lock input. Without it the arbiter
//                 always rotates priority past the accepted requester.
// ---------------------------------------------------------------------------
module rr_arb8_idx
   import arb_pkg::*;
#(
   parameter int N    = arb_pkg::N,
   parameter int IDXW = arb_pkg::IDXW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            gnt_ready,
`ifdef ARB_LOCK_EN
   input  logic            lock,
`endif
   output logic            gnt_vld,
   output logic [IDXW-1:0] gnt_idx,
   output logic [CNTW-1:0] gnt_cnt
);

   state_e          state_q, state_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [CNTW-1:0] cnt_q, cnt_d;

   logic            lockEff;
   logic            accept;
   logic [IDXW-1:0] searchPtr;
   logic [IDXW-1:0] pickIdx;
   logic            pickAny;

`ifdef ARB_LOCK_EN
   assign lockEff = lock;
`else
   assign lockEff = 1'b0;
`endif

   assign accept = (state_q == OFFER) && gnt_ready;

   // Where the next search starts. While idle the stored pointer is used.
   // On an accept the search must already see the updated priority so a new
   // grant can be offered without a bubble: normally one past the winner,
   // but with lock held the search starts at the winner itself so the same
   // index is re-offered while its request stays high.
   always_comb begin
      searchPtr = ptr_q;
      if (state_q == OFFER) begin
         searchPtr = lockEff ? idx_q : idx_q + IDXW'(1);
      end
   end

   rr_pick8 u_pick (
      .req (req),
      .ptr (searchPtr),
      .idx (pickIdx),
      .any (pickAny)
   );

   // Next-state logic. An offer is frozen until accepted, regardless of what
   // req does meanwhile. On accept the pointer moves past the winner (unless
   // locked), the counter advances, and either the next winner is offered
   // straight away or the arbiter falls back to idle with gnt_idx untouched.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (pickAny) begin
               idx_d   = pickIdx;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (accept) begin
               ptr_d = lockEff ? ptr_q : idx_q + IDXW'(1);
               cnt_d = cnt_q + CNTW'(1);
               if (pickAny) begin
                  idx_d = pickIdx;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Single state register for the FSM and its outputs. Reset wins over
   // everything, including a grant being accepted in the same cycle, so a
   // pending offer is dropped without being counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt_vld = (state_q == OFFER);
   assign gnt_idx = idx_q;
   assign gnt_cnt = cnt_q;

endmodule

// File: tb/tb_rr_arb8_idx.sv
// ---------------------------------------------------------------------------
// tb_rr_arb8_idx
// Directed, table-driven bench for the round-robin index arbiter. Each table
// row gives the inputs held across one rising edge and the outputs expected
// just after it. Extra hand-written sequences cover counter wrap and, when
// ARB_LOCK_EN is defined, the lock behaviour.
// ---------------------------------------------------------------------------
module tb_rr_arb8_idx;

   typedef struct packed {
      logic       rst;
      logic [7:0] req;
      logic       rdy;
      logic       expVld;
      logic       chkIdx;
      logic [2:0] expIdx;
      logic [7:0] expCnt;
   } vec_t;

   localparam int NVEC = 32;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       gnt_ready;
   logic       lockIn;
   logic       gnt_vld;
   logic [2:0] gnt_idx;
   logic [7:0] gnt_cnt;

   int checks;
   int errors;

   vec_t vecs [NVEC];

   rr_arb8_idx dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt_ready (gnt_ready),
`ifdef ARB_LOCK_EN
      .lock      (lockIn),
`endif
      .gnt_vld   (gnt_vld),
      .gnt_idx   (gnt_idx),
      .gnt_cnt   (gnt_cnt)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one set of inputs, let one rising edge happen, then settle 1 unit
   // past the edge so outputs are sampled away from it.
   task automatic applyStimulus(input logic r, input logic [7:0] rq,
                                input logic rdy, input logic lk);
      rst       = r;
      req       = rq;
      gnt_ready = rdy;
      lockIn    = lk;
      @(posedge clk);
      #1;
   endtask

   // Compare the three outputs against expectations; gnt_idx is skipped when
   // its value is not defined by the stimulus.
   task automatic checkOutput(input string name, input logic expVld,
                              input logic chkIdx, input logic [2:0] expIdx,
                              input logic [7:0] expCnt);
      checks++;
      if (gnt_vld !== expVld) begin
         errors++;
         $display("[TB] FAIL %s gnt_vld: got %0b expected %0b", name, gnt_vld, expVld);
      end
      if (chkIdx) begin
         checks++;
         if (gnt_idx !== expIdx) begin
            errors++;
            $display("[TB] FAIL %s gnt_idx: got %0d expected %0d", name, gnt_idx, expIdx);
         end
      end
      checks++;
      if (gnt_cnt !== expCnt) begin
         errors++;
         $display("[TB] FAIL %s gnt_cnt: got %0d expected %0d", name, gnt_cnt, expCnt);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      req       = 8'h00;
      gnt_ready = 1'b0;
      lockIn    = 1'b0;

      //                rst   req    rdy   vld   chk   idx   cnt
      // Single request: grant 2 one cycle later, accept, back to idle.
      vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'd0};
      vecs[1]  = '{1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 3'd2, 8'd0};
      vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1};
      vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 8'd1};
      // All requests with ready held: 0..7,0,1 with no bubbles.
      vecs[4]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'd0};
      vecs[5]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd0, 8'd0};
      vecs[6]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd1, 8'd1};
      vecs[7]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd2, 8'd2};
      vecs[8]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd3, 8'd3};
      vecs[9]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd4, 8'd4};
      vecs[10] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd5, 8'd5};
      vecs[11] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd6, 8'd6};
      vecs[12] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 8'd7};
      vecs[13] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd0, 8'd8};
      vecs[14] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd1, 8'd9};
      // Pointer at 1 with req 7 and 0: grant 7, wrap, grant 0, then 7 again.
      vecs[15] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'd0};
      vecs[16] = '{1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 3'd0, 8'd0};
      vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1};
      vecs[18] = '{1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 3'd7, 8'd1};
      vecs[19] = '{1'b0, 8'h81, 1'b1, 1'b1, 1'b1, 3'd0, 8'd2};
      vecs[20] = '{1'b0, 8'h81, 1'b1, 1'b1, 1'b1, 3'd7, 8'd3};
      vecs[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'd4};
      // Offer 3 stalled five cycles while req[3] drops and req wanders.
      vecs[22] = '{1'b0, 8'h08, 1'b0, 1'b1, 1'b1, 3'd3, 8'd4};
      vecs[23] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 8'd4};
      vecs[24] = '{1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 3'd3, 8'd4};
      vecs[25] = '{1'b0, 8'hF7, 1'b0, 1'b1, 1'b1, 3'd3, 8'd4};
      vecs[26] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 8'd4};
      vecs[27] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 3'd3, 8'd4};
      // Accept 3 into offer 5, then reset with ready high: grant not counted,
      // and the next search starts from 0.
      vecs[28] = '{1'b0, 8'h20, 1'b1, 1'b1, 1'b1, 3'd5, 8'd5};
      vecs[29] = '{1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 3'd0, 8'd0};
      vecs[30] = '{1'b0, 8'h21, 1'b0, 1'b1, 1'b1, 3'd0, 8'd0};
      vecs[31] = '{1'b0, 8'h21, 1'b1, 1'b1, 1'b1, 3'd5, 8'd1};

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].rdy, 1'b0);
         checkOutput($sformatf("vec%0d", i), vecs[i].expVld, vecs[i].chkIdx,
                     vecs[i].expIdx, vecs[i].expCnt);
      end

      // Counter wrap: 256 back-to-back accepts on all requests brings the
      // count back to 0 while the index cycles in ascending order.
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0);
      checkOutput("wrapStart", 1'b1, 1'b1, 3'd0, 8'd0);
      for (int k = 1; k <= 256; k++) begin
         applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0);
         if (k == 255) checkOutput("wrap255", 1'b1, 1'b1, 3'd7, 8'd255);
         if (k == 256) checkOutput("wrap256", 1'b1, 1'b1, 3'd0, 8'd0);
      end

`ifdef ARB_LOCK_EN
      // Lock held on each accept keeps re-offering 1; releasing it moves on to 3.
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h0A, 1'b0, 1'b1);
      checkOutput("lockFirst", 1'b1, 1'b1, 3'd1, 8'd0);
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1'b0, 8'h0A, 1'b1, 1'b1);
         checkOutput($sformatf("lockHold%0d", k), 1'b1, 1'b1, 3'd1, 8'(k));
      end
      applyStimulus(1'b0, 8'h0A, 1'b1, 1'b0);
      checkOutput("lockRelease", 1'b1, 1'b1, 3'd3, 8'd4);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
